// File: rtl/lutram_rd_pkg.sv
// ============================================================================
// Module      : lutram_rd_pkg
// Description : Shared defaults and FSM state type for the LUTRAM burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lutram_rd_pkg;

    localparam int c_DATA_W     = 200;
    localparam int c_ADDR_W     = 13;
    localparam int c_MEM_DEPTH  = 8000;
    localparam int c_RD_LAT     = 2;
    localparam int c_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lutram_rd_fifo.sv
// ============================================================================
// Module      : lutram_rd_fifo
// Description : Synchronous show-ahead FIFO with occupancy count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lutram_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != (c_PTR_W+1)'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/lutram_burst_reader.sv
// ============================================================================
// Module      : lutram_burst_reader
// Description : Credit-throttled burst reader from a fixed-latency LUTRAM into
//               a valid/ready stream. Optional stall counter enabled by
//               LUTRAM_BURST_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lutram_burst_reader
    import lutram_rd_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W,
    parameter int ADDR_W     = c_ADDR_W,
    parameter int MEM_DEPTH  = c_MEM_DEPTH,
    parameter int RD_LAT     = c_RD_LAT,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_enb,
    output logic [ADDR_W-1:0] mem_addrb,
    input  logic [DATA_W-1:0] mem_doutb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef LUTRAM_BURST_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int               c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               c_CNT_W    = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam logic [ADDR_W:0]  c_DEPTH_L  = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = ADDR_W'(MEM_DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_left;
    logic [RD_LAT-1:0]   r_vpipe;
    logic [RD_LAT-1:0]   r_lpipe;
    logic                r_err;
    logic                r_zdone;

    logic                w_enb;
    logic                w_accept;
    logic                w_reject;
    logic                w_zero;
    logic                w_last_rd;
    logic                w_pop;
    logic                w_last_xfer;
    logic                w_credit_ok;
    logic [c_CNT_W-1:0]  w_inflight;
    logic                w_fifo_empty;
    logic                w_fifo_last;
    logic [DATA_W-1:0]   w_fifo_data;
    logic [c_PTR_W:0]    w_fifo_count;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + c_CNT_W'(r_vpipe[i]);
        end
    end

    // Every read in flight already owns a FIFO slot, so the FIFO cannot overflow.
    assign w_credit_ok = (w_inflight + c_CNT_W'(w_fifo_count)) < c_CNT_W'(FIFO_DEPTH);
    assign w_last_rd   = (r_left == (ADDR_W+1)'(1));
    assign w_pop       = !w_fifo_empty && m_ready;
    assign w_last_xfer = w_pop && w_fifo_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_enb       = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_zero      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if ({1'b0, base_addr} >= c_DEPTH_L) begin
                        w_reject = 1'b1;
                    end else if (length == '0) begin
                        w_zero = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                w_enb = w_credit_ok;
                if (w_credit_ok && w_last_rd) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_xfer) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_left  <= '0;
            r_vpipe <= '0;
            r_lpipe <= '0;
            r_err   <= 1'b0;
            r_zdone <= 1'b0;
        end else begin
            r_err   <= w_reject;
            r_zdone <= w_zero;
            if (w_accept) begin
                r_addr <= base_addr;
                r_left <= length;
            end else if (w_enb) begin
                r_addr <= (r_addr == c_ADDR_MAX) ? '0 : r_addr + 1'b1;
                r_left <= r_left - 1'b1;
            end
            r_vpipe[0] <= w_enb;
            r_lpipe[0] <= w_enb && w_last_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_lpipe[i] <= r_lpipe[i-1];
            end
        end
    end

    lutram_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_vpipe[RD_LAT-1]),
        .i_din   ({r_lpipe[RD_LAT-1], mem_doutb}),
        .i_pop   (w_pop),
        .o_dout  ({w_fifo_last, w_fifo_data}),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_zdone || ((r_state == ST_DRAIN) && w_last_xfer);
    assign err       = r_err;
    assign mem_enb   = w_enb;
    assign mem_addrb = r_addr;
    assign m_valid   = !w_fifo_empty;
    assign m_data    = w_fifo_data;
    assign m_last    = !w_fifo_empty && w_fifo_last;

`ifdef LUTRAM_BURST_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (m_valid && !m_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lutram_burst_reader.sv
// ============================================================================
// Module      : tb_lutram_burst_reader
// Description : Scoreboard bench for lutram_burst_reader with a latency-2
//               memory model. Checks stall_cnt when LUTRAM_BURST_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lutram_burst_reader;

    localparam int DW  = 200;
    localparam int AW  = 13;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, err, mem_enb, m_valid, m_last;
    logic          m_ready = 1'b0;
    logic [AW-1:0] mem_addrb;
    logic [DW-1:0] mem_doutb, m_data;
`ifdef LUTRAM_BURST_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int enb_cnt = 0;

    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];
    logic          q_last [$];

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW-1:0] rd_pipe [LAT];

    always #5 clk = ~clk;

    lutram_burst_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_enb   (mem_enb),
        .mem_addrb (mem_addrb),
        .mem_doutb (mem_doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
`ifdef LUTRAM_BURST_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .m_last    (m_last)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[i*25 +: 25] = {12'(i * 37 + 5), a} ^ 25'h0155AA5;
        end
        return w;
    endfunction

    // Memory model: data appears LAT cycles after the enable is sampled.
    always @(posedge clk) begin
        rd_pipe[0] <= mem_enb ? mem_word(mem_addrb) : {25{8'hEE}};
        for (int i = 1; i < LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_doutb = rd_pipe[LAT-1];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_enb) begin
                enb_cnt++;
                if (q_addr.size() == 0) check("rd_unexpected", 256'(1), 256'(0));
                else check("rd_addr", 256'(mem_addrb), 256'(q_addr.pop_front()));
            end
            if (prev_stall && m_valid) begin
                check("hold_data", 256'(m_data), 256'(prev_data));
                check("hold_last", 256'(m_last), 256'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (q_data.size() == 0) check("word_unexpected", 256'(1), 256'(0));
                else begin
                    check("word_data", 256'(m_data), 256'(q_data.pop_front()));
                    check("word_last", 256'(m_last), 256'(q_last.pop_front()));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Called at posedge+1; returns one edge later with start already sampled.
    task automatic go(input int b, input int l, input bit acc);
        start     = 1'b1;
        base_addr = AW'(b);
        length    = (AW+1)'(l);
        if (acc) begin
            for (int i = 0; i < l; i++) begin
                q_addr.push_back(AW'((b + i) % 8000));
                q_data.push_back(mem_word(AW'((b + i) % 8000)));
                q_last.push_back(i == l - 1);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 256'(seen), 256'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  256'(busy),      256'(0));
        check({tag, "_done"},  256'(done),      256'(0));
        check({tag, "_err"},   256'(err),       256'(0));
        check({tag, "_enb"},   256'(mem_enb),   256'(0));
        check({tag, "_valid"}, 256'(m_valid),   256'(0));
        check({tag, "_last"},  256'(m_last),    256'(0));
        check({tag, "_addr"},  256'(mem_addrb), 256'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int e0;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst, full-rate consumer.
        m_ready = 1'b1;
        go(10, 5, 1'b1);
        check("b1_busy", 256'(busy), 256'(1));
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (m_valid) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check("b1_latency", 256'(lat), 256'(3));
        for (int w = 0; w < 5; w++) begin
            check("b1_stream", 256'(m_valid), 256'(1));
            check("b1_last_pos", 256'(m_last), 256'(w == 4));
            check("b1_done_pos", 256'(done), 256'(w == 4));
            @(posedge clk);
            #1;
        end
        check("b1_busy_end", 256'(busy), 256'(0));
        check("b1_done_end", 256'(done), 256'(0));

        // Address wrap at the top of memory.
        e0 = enb_cnt;
        go(7998, 4, 1'b1);
        wait_done(40);
        check("wrap_reads", 256'(enb_cnt - e0), 256'(4));

        // Backpressure: credits bound the reads, stall counter tracks cycles.
        m_ready = 1'b0;
        e0 = enb_cnt;
        go(300, 16, 1'b1);
`ifdef LUTRAM_BURST_STALL_CNT_EN
        check("stall_start", 256'(stall_cnt), 256'(0));
`endif
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (m_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("stall_valid_seen", 256'(seen), 256'(1));
        go(5, 3, 1'b0);
        check("busy_start_err", 256'(err), 256'(0));
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        check("credit_bound", 256'((enb_cnt - e0) <= 4), 256'(1));
        check("stall_valid_hold", 256'(m_valid), 256'(1));
`ifdef LUTRAM_BURST_STALL_CNT_EN
        check("stall_cnt", 256'(stall_cnt), 256'(20));
`endif
        m_ready = 1'b1;
        wait_done(80);
`ifdef LUTRAM_BURST_STALL_CNT_EN
        check("stall_cnt_after", 256'(stall_cnt), 256'(20));
`endif

        // Rejected start and zero-length burst.
        e0 = enb_cnt;
        go(8000, 3, 1'b0);
        check("err_pulse", 256'(err), 256'(1));
        check("err_busy", 256'(busy), 256'(0));
        @(posedge clk);
        #1;
        check("err_one_cycle", 256'(err), 256'(0));
        go(50, 0, 1'b0);
        check("zero_done", 256'(done), 256'(1));
        check("zero_busy", 256'(busy), 256'(0));
        @(posedge clk);
        #1;
        check("zero_done_one_cycle", 256'(done), 256'(0));
        repeat (4) @(posedge clk);
        #1;
        check("no_reads", 256'(enb_cnt - e0), 256'(0));

        // Reset in the middle of a burst.
        go(100, 8, 1'b1);
`ifdef LUTRAM_BURST_STALL_CNT_EN
        check("stall_clr_on_start", 256'(stall_cnt), 256'(0));
`endif
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        q_addr.delete();
        q_data.delete();
        q_last.delete();
        #1;
        check_idle_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("stale_valid", 256'(m_valid), 256'(0));
        end
        @(posedge clk);
        #1;
        go(200, 6, 1'b1);
        wait_done(40);

        check("sb_addr_empty", 256'(q_addr.size()), 256'(0));
        check("sb_data_empty", 256'(q_data.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lutram_burst_reader.md
LUTRAM_BURST_READER -- requirements
Module: lutram_burst_reader

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  DATA_W  200  word width
  ADDR_W  13  address width
  MEM_DEPTH  8000  words in the memory; addresses wrap modulo this value
  RD_LAT  2  memory read latency, enb to doutb
  FIFO_DEPTH  4  output buffer entries, power of two
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all logic rising-edge
  rst_n  in  1  asynchronous active-low reset
  start  in  1  one-cycle burst request
  base_addr  in  ADDR_W  first word address
  length  in  ADDR_W+1  word count, 0..MEM_DEPTH
  busy  out  1  burst in progress
  done  out  1  one-cycle pulse when the burst completes
  err  out  1  one-cycle pulse when a start is rejected
  mem_enb  out  1  memory read enable
  mem_addrb  out  ADDR_W  memory read address
  mem_doutb  in  DATA_W  memory read data, RD_LAT cycles after mem_enb
  m_valid  out  1  stream word available
  m_ready  in  1  consumer accepts the word
  m_data  out  DATA_W  stream word
  m_last  out  1  marks the final word of the burst

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and DRAIN.
REQ-004 start in IDLE with base_addr < MEM_DEPTH and length > 0 SHALL move the FSM to ISSUE on the next cycle and raise busy.
REQ-005 start in IDLE with base_addr >= MEM_DEPTH SHALL pulse err on the next cycle, issue no reads and keep the FSM in IDLE.
REQ-006 start in IDLE with length == 0 SHALL pulse done on the next cycle and issue no reads.
REQ-007 start while busy SHALL be ignored, with no err pulse.
REQ-008 In ISSUE, mem_enb SHALL assert only when the number of in-flight reads plus the FIFO occupancy is less than FIFO_DEPTH (credit rule); the FIFO SHALL never overflow.
REQ-009 mem_addrb SHALL start at base_addr and increment by 1 per issued read, wrapping from MEM_DEPTH-1 to 0.
REQ-010 When the last read issues, the FSM SHALL move to DRAIN.
REQ-011 A RD_LAT-deep valid/last shift register SHALL track in-flight reads; mem_doutb SHALL be written into the FIFO exactly RD_LAT cycles after its mem_enb.
REQ-012 A word transfers on m_valid && m_ready; m_data and m_last SHALL hold stable while m_valid && !m_ready.
REQ-013 m_last SHALL be 1 only on word number length-1 of the burst.
REQ-014 When the m_last word transfers, the FSM SHALL return to IDLE, pulse done in that same cycle and drop busy.
REQ-015 With m_ready held high, throughput SHALL be one word per cycle after an initial latency of RD_LAT+1 cycles from start to first m_valid.
REQ-016 A FIFO push and pop in the same cycle SHALL be legal and SHALL leave the occupancy unchanged.

Reset
REQ-017 While rst_n is low, the FSM SHALL be in IDLE and busy, done, err, mem_enb, m_valid and m_last SHALL be 0; mem_addrb SHALL be 0.
REQ-018 Reset asserted mid-burst SHALL clear in-flight tracking and FIFO occupancy; memory data arriving after reset SHALL be discarded.
REQ-019 m_data is don't-care while m_valid is 0.

Configuration
REQ-020 With LUTRAM_BURST_STALL_CNT_EN defined, the block SHALL add a 32-bit output stall_cnt that:
  - counts cycles with m_valid && !m_ready;
  - saturates at 0xFFFFFFFF;
  - clears on reset and on each accepted start.
REQ-021 Without LUTRAM_BURST_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent.

Structure
REQ-022 Package lutram_rd_pkg SHALL hold the parameter defaults and the FSM state enum typedef.
REQ-023 The output buffer SHALL be a sub-module lutram_rd_fifo: synchronous, FIFO_DEPTH entries, with count output and show-ahead read.

Verification
REQ-024 The bench SHALL cover at least these scenarios:
  - base_addr=10, length=5, m_ready=1 -> reads 10..14; first m_valid 3 cycles after start; 5 consecutive words; m_last on word 4; done on its transfer.
  - base_addr=7998, length=4 -> mem_addrb sequence 7998, 7999, 0, 1.
  - length=16, m_ready=0 for 20 cycles -> at most 4 reads issued; no FIFO overflow; data order intact after release; stall_cnt=20 when the macro is defined.
  - base_addr=8000 -> err pulse, busy stays 0, no mem_enb; length=0 -> done pulse, no mem_enb.
  - rst_n low for 1 cycle mid-burst -> all outputs 0; no m_valid from stale reads; a new burst completes correctly afterwards.
